uart_cmd_rx: RTL and testbench

// - UART receiver (8N1) that turns the serial host line into the byte/strobe pair consumed by the

---
 rtl/uart_cmd_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver: turns the serial host line into cmd[7:0] plus a rd strobe per good byte.
// Each bit is decided by a three-sample majority vote around mid-bit; frames with a bad stop bit are flagged and dropped.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned RD_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] cmd,
    output logic       rd,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TICK_RATE = BAUD * OVERSAMPLE;
    localparam int unsigned DIV       = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
    localparam int unsigned TCNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W       = $clog2(OVERSAMPLE);
    localparam int unsigned RDC_W     = (RD_WIDTH > 1) ? $clog2(RD_WIDTH) : 1;
    localparam int unsigned S_MID_LO  = OVERSAMPLE / 2 - 1;
    localparam int unsigned S_MID     = OVERSAMPLE / 2;
    localparam int unsigned S_MID_HI  = OVERSAMPLE / 2 + 1;
    localparam int unsigned S_LAST    = OVERSAMPLE - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        DELIVER = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               rx_m;
    logic               rx_s;
    logic               rx_prev;
    logic               edge_pend;
    logic [TCNT_W-1:0]  tcnt;
    logic [S_W-1:0]     s_cnt;
    logic [2:0]         bit_cnt;
    logic [RDC_W-1:0]   rd_cnt;
    logic               smp_lo;
    logic               smp_mid;
    logic [7:0]         shift;

    logic               tick_c;
    logic               fall_c;
    logic               start_c;
    logic               maj_c;
    logic               mid_dec_c;
    logic               bit_end_c;
    logic               rd_done_c;

    logic [7:0]         cmd_nxt;
    logic               rd_nxt;
    logic               frame_err_nxt;
    logic               busy_nxt;

    // Decode helpers shared by the FSM and the datapath
    always_comb begin
        tick_c    = (state != IDLE) && (tcnt == TCNT_W'(DIV - 32'd1));
        fall_c    = rx_prev & ~rx_s;
        // A falling edge seen during DELIVER is remembered so IDLE still accepts it
        start_c   = (state == IDLE) && (fall_c || (edge_pend && !rx_s));
        maj_c     = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);
        mid_dec_c = tick_c && (s_cnt == S_W'(S_MID_HI));
        bit_end_c = tick_c && (s_cnt == S_W'(S_LAST));
        rd_done_c = (rd_cnt == RDC_W'(RD_WIDTH - 32'd1));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_c) state_nxt = START;
            end
            START: begin
                if (mid_dec_c && maj_c) state_nxt = IDLE;
                else if (bit_end_c)     state_nxt = DATA;
            end
            DATA: begin
                if (bit_end_c && (bit_cnt == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                if (mid_dec_c) state_nxt = maj_c ? DELIVER : WAIT_HI;
            end
            DELIVER: begin
                if (rd_done_c) state_nxt = IDLE;
            end
            WAIT_HI: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output logic; values are registered below
    always_comb begin
        cmd_nxt       = cmd;
        rd_nxt        = 1'b0;
        frame_err_nxt = 1'b0;
        busy_nxt      = 1'b0;
        if ((state == STOP) && mid_dec_c) begin
            if (maj_c) cmd_nxt       = shift;
            else       frame_err_nxt = 1'b1;
        end
        if (state == DELIVER) rd_nxt = 1'b1;
        case (state_nxt)
            START, DATA, STOP, WAIT_HI: busy_nxt = 1'b1;
            default:                    busy_nxt = 1'b0;
        endcase
    end

    // Synchronizer, oversampling counters and shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            edge_pend <= 1'b0;
            tcnt      <= '0;
            s_cnt     <= '0;
            bit_cnt   <= '0;
            rd_cnt    <= '0;
            smp_lo    <= 1'b1;
            smp_mid   <= 1'b1;
            shift     <= '0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_prev   <= rx_s;
            edge_pend <= (state == DELIVER) && (edge_pend || fall_c);

            if (state == IDLE) begin
                tcnt  <= '0;
                s_cnt <= '0;
            end else if (tick_c) begin
                tcnt  <= '0;
                s_cnt <= (s_cnt == S_W'(S_LAST)) ? '0 : s_cnt + S_W'(1);
            end else begin
                tcnt  <= tcnt + TCNT_W'(1);
            end

            if (tick_c && (s_cnt == S_W'(S_MID_LO))) smp_lo  <= rx_s;
            if (tick_c && (s_cnt == S_W'(S_MID)))    smp_mid <= rx_s;

            if ((state == DATA) && mid_dec_c) shift <= {maj_c, shift[7:1]};

            if (state == START)                    bit_cnt <= '0;
            else if ((state == DATA) && bit_end_c) bit_cnt <= bit_cnt + 3'd1;

            rd_cnt <= (state == DELIVER) ? rd_cnt + RDC_W'(1) : '0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd       <= 8'h00;
            rd        <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd       <= cmd_nxt;
            rd        <= rd_nxt;
            frame_err <= frame_err_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial frames driven bit by bit, strobe behaviour recorded by a monitor.
module tb_uart_cmd_rx;

    localparam int BIT_CLKS = 432;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] cmd;
    logic       rd;
    logic       frame_err;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (115200),
        .OVERSAMPLE(16),
        .RD_WIDTH  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .cmd      (cmd),
        .rd       (rd),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Monitor: records each rd pulse, its cmd and how long cmd had been stable
    logic       rd_q   = 1'b0;
    logic       fe_q   = 1'b0;
    logic       busy_q = 1'b0;
    logic [7:0] cmd_q  = 8'h00;
    int cmd_age = 0, rd_len = 0, fe_len = 0;
    int bad_rd_len = 0, bad_fe_len = 0, fe_count = 0, busy_rises = 0;
    int overlap = 0, cmd_chg_in_rd = 0;
    logic [7:0] rec_cmd[$];
    int         rec_age[$];

    always @(negedge clk) begin
        if (cmd !== cmd_q) cmd_age = 0;
        else if (cmd_age < 1000000) cmd_age = cmd_age + 1;
        if (rd === 1'b1 && cmd !== cmd_q) cmd_chg_in_rd = cmd_chg_in_rd + 1;
        if (rd === 1'b1 && rd_q !== 1'b1) begin
            rec_cmd.push_back(cmd);
            rec_age.push_back(cmd_age);
            rd_len = 1;
        end else if (rd === 1'b1) begin
            rd_len = rd_len + 1;
        end
        if (rd !== 1'b1 && rd_q === 1'b1 && rd_len != 4) bad_rd_len = bad_rd_len + 1;
        if (frame_err === 1'b1 && fe_q !== 1'b1) begin
            fe_count = fe_count + 1;
            fe_len   = 1;
        end else if (frame_err === 1'b1) begin
            fe_len = fe_len + 1;
        end
        if (frame_err !== 1'b1 && fe_q === 1'b1 && fe_len != 1) bad_fe_len = bad_fe_len + 1;
        if (rd === 1'b1 && frame_err === 1'b1) overlap = overlap + 1;
        if (busy === 1'b1 && busy_q !== 1'b1) busy_rises = busy_rises + 1;
        rd_q   = rd;
        fe_q   = frame_err;
        busy_q = busy;
        cmd_q  = cmd;
    end

    function automatic logic [7:0] rec_at(input int i);
        if (i < rec_cmd.size()) return rec_cmd[i];
        return 8'hxx;
    endfunction

    function automatic int age_at(input int i);
        if (i < rec_age.size()) return rec_age[i];
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_clks(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_v);
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
        drive_bit(stop_v, bclk);
    endtask

    initial begin
        logic [7:0] msg [5];
        logic [7:0] b41;
        int         snap;

        msg[0] = 8'h66; msg[1] = 8'h31; msg[2] = 8'h32; msg[3] = 8'h33; msg[4] = 8'h34;
        b41    = 8'h41;

        // Reset with the line held low
        rst_n = 1'b0;
        rx    = 1'b0;
        wait_clks(5);
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_rd", rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        rx    = 1'b1;
        rst_n = 1'b1;
        wait_clks(50);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_rd", rec_cmd.size(), 0);

        // Single 'f' at nominal rate
        send_byte(8'h66, BIT_CLKS, 1'b1);
        wait_clks(BIT_CLKS);
        chk("f_count", rec_cmd.size(), 1);
        chk("f_cmd", rec_at(0), 8'h66);
        chk("f_cmd_lead", age_at(0), 1);
        chk("f_ferr", fe_count, 0);
        chk("f_busy_idle", busy, 0);
        chk("f_rd_len", bad_rd_len, 0);

        // "f1234" back-to-back with no idle gap
        for (int i = 0; i < 5; i++) send_byte(msg[i], BIT_CLKS, 1'b1);
        wait_clks(600);
        chk("str_count", rec_cmd.size(), 6);
        for (int i = 0; i < 5; i++) chk($sformatf("str_cmd%0d", i), rec_at(1 + i), msg[i]);
        chk("str_lead_last", age_at(5), 1);
        chk("str_ferr", fe_count, 0);

        // 0x55 with stop bit low, line then held low for three bit times
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1, BIT_CLKS);
        drive_bit(1'b0, 3 * BIT_CLKS);
        chk("brk_ferr_once", fe_count, 1);
        chk("brk_no_rd", rec_cmd.size(), 6);
        chk("brk_cmd_kept", cmd, 8'h34);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        chk("brk_ferr_after", fe_count, 1);
        chk("brk_ferr_len", bad_fe_len, 0);
        chk("brk_busy_idle", busy, 0);

        // 100-clk glitch on idle line
        snap = busy_rises;
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 600);
        chk("glitch_busy_pulse", busy_rises - snap, 1);
        chk("glitch_busy_idle", busy, 0);
        chk("glitch_no_rd", rec_cmd.size(), 6);
        chk("glitch_no_ferr", fe_count, 1);

        // 0x31 at +3% and -3% baud
        send_byte(8'h31, 419, 1'b1);
        wait_clks(BIT_CLKS);
        send_byte(8'h31, 445, 1'b1);
        wait_clks(BIT_CLKS);
        chk("baud_count", rec_cmd.size(), 8);
        chk("baud_fast_cmd", rec_at(6), 8'h31);
        chk("baud_slow_cmd", rec_at(7), 8'h31);
        chk("baud_ferr", fe_count, 1);

        // Reset during data bit 4 of 0x41, then a clean 0x42
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(b41[i], BIT_CLKS);
        rx    = b41[4];
        rst_n = 1'b0;
        wait_clks(5);
        chk("midrst_cmd", cmd, 8'h00);
        chk("midrst_busy", busy, 0);
        rx    = 1'b1;
        rst_n = 1'b1;
        wait_clks(1000);
        chk("midrst_no_rd", rec_cmd.size(), 8);
        chk("midrst_busy_idle", busy, 0);
        send_byte(8'h42, BIT_CLKS, 1'b1);
        wait_clks(BIT_CLKS);
        chk("after_rst_count", rec_cmd.size(), 9);
        chk("after_rst_cmd", rec_at(8), 8'h42);
        chk("after_rst_lead", age_at(8), 1);
        chk("after_rst_hold", cmd, 8'h42);
        chk("after_rst_ferr", fe_count, 1);

        // Whole-run strobe properties
        chk("all_rd_len", bad_rd_len, 0);
        chk("all_rd_ferr_overlap", overlap, 0);
        chk("all_cmd_stable_in_rd", cmd_chg_in_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
